// File: rtl/risk_tile_walker_if.sv
// Command channel from the tile walker to the risk engine: one tile per valid/ready handshake.
interface risk_tile_walker_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_func;
    logic [4:0]  cmd_reg;
    logic [14:0] cmd_addr;
    logic [13:0] cmd_stride_x;
    logic [13:0] cmd_stride_y;
    logic [5:0]  tile_x;
    logic [5:0]  tile_y;

    modport master (
        output cmd_valid, cmd_func, cmd_reg, cmd_addr, cmd_stride_x, cmd_stride_y,
               tile_x, tile_y,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_func, cmd_reg, cmd_addr, cmd_stride_x, cmd_stride_y,
               tile_x, tile_y,
        output cmd_ready
    );
endinterface

// File: rtl/risk_tile_walker.sv
// Walks a tiles_x by tiles_y grid of TILE x TILE tiles in raster order and issues
// one risk command per tile; the tile origin address is advanced incrementally.
module risk_tile_walker #(
    parameter int unsigned GAP  = 0,
    parameter int unsigned TILE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [14:0] base_addr,
    input  logic [5:0]  tiles_x,
    input  logic [5:0]  tiles_y,
    input  logic [13:0] row_stride,
    input  logic [2:0]  func_in,
    input  logic [4:0]  reg_in,
    risk_tile_walker_if.master cmd,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW         = 15;
    localparam int unsigned SW         = 14;
    localparam int unsigned TW         = 6;
    localparam int unsigned CW         = 4;
    localparam int unsigned TILE_SHIFT = $clog2(TILE);
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP == 0) ? 0 : GAP - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

    state_t        state;
    logic [TW-1:0] tiles_x_q;
    logic [TW-1:0] tiles_y_q;
    logic [AW-1:0] row_base;
    logic [CW-1:0] gap_cnt;

    logic          hs;
    logic          last_x;
    logic          last_y;
    logic          empty;
    logic [AW-1:0] row_step;
    logic [AW-1:0] row_next;

    assign hs       = cmd.cmd_valid & cmd.cmd_ready;
    assign last_x   = (cmd.tile_x == tiles_x_q - TW'(1));
    assign last_y   = (cmd.tile_y == tiles_y_q - TW'(1));
    assign empty    = (tiles_x == '0) || (tiles_y == '0);
    // One tile row down is TILE matrix rows, i.e. row_stride scaled by TILE (mod 2^15).
    assign row_step = AW'(32'(cmd.cmd_stride_y) << TILE_SHIFT);
    assign row_next = row_base + row_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            tiles_x_q        <= '0;
            tiles_y_q        <= '0;
            row_base         <= '0;
            gap_cnt          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            cmd.cmd_valid    <= 1'b0;
            cmd.cmd_func     <= '0;
            cmd.cmd_reg      <= '0;
            cmd.cmd_addr     <= '0;
            cmd.cmd_stride_x <= SW'(1);
            cmd.cmd_stride_y <= '0;
            cmd.tile_x       <= '0;
            cmd.tile_y       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        if (empty) begin
                            done <= 1'b1;
                        end else begin
                            tiles_x_q        <= tiles_x;
                            tiles_y_q        <= tiles_y;
                            row_base         <= base_addr;
                            cmd.cmd_addr     <= base_addr;
                            cmd.cmd_stride_y <= row_stride;
                            cmd.cmd_func     <= func_in;
                            cmd.cmd_reg      <= reg_in;
                            cmd.tile_x       <= '0;
                            cmd.tile_y       <= '0;
                            cmd.cmd_valid    <= 1'b1;
                            busy             <= 1'b1;
                            state            <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        cmd.cmd_valid <= 1'b0;
                        busy          <= 1'b0;
                        state         <= S_IDLE;
                    end else if (hs) begin
                        if (last_x && last_y) begin
                            cmd.cmd_valid <= 1'b0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= S_IDLE;
                        end else begin
                            if (last_x) begin
                                cmd.tile_x   <= '0;
                                cmd.tile_y   <= cmd.tile_y + TW'(1);
                                row_base     <= row_next;
                                cmd.cmd_addr <= row_next;
                            end else begin
                                cmd.tile_x   <= cmd.tile_x + TW'(1);
                                cmd.cmd_addr <= cmd.cmd_addr + AW'(TILE);
                            end
                            // Next tile is already loaded; GAP only delays when it is shown.
                            if (GAP != 0) begin
                                cmd.cmd_valid <= 1'b0;
                                gap_cnt       <= GAP_LAST;
                                state         <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (gap_cnt == '0) begin
                        cmd.cmd_valid <= 1'b1;
                        state         <= S_ISSUE;
                    end else begin
                        gap_cnt <= gap_cnt - CW'(1);
                    end
                end
                default: begin
                    cmd.cmd_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risk_tile_walker.sv
// Bench for risk_tile_walker: a GAP=0 and a GAP=2 instance share stimulus and are
// checked against an arithmetic model of the raster walk.
module tb_risk_tile_walker;

    typedef logic [48:0] rec_t;

    logic        clk = 1'b0;
    logic        reset, start, abort, ready;
    logic [14:0] base_addr;
    logic [5:0]  tiles_x, tiles_y;
    logic [13:0] row_stride;
    logic [2:0]  func_in;
    logic [4:0]  reg_in;
    logic        busy0, done0, busy2, done2;

    int n_cmp = 0;
    int n_err = 0;

    rec_t       hs0[$], hs2[$], exp_q[$];
    logic [1:0] tr0[$], tr2[$];
    int         dn0, dn2;

    risk_tile_walker_if if0();
    risk_tile_walker_if if2();
    assign if0.cmd_ready = ready;
    assign if2.cmd_ready = ready;

    risk_tile_walker #(.GAP(0), .TILE(4)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .base_addr(base_addr),
        .tiles_x(tiles_x), .tiles_y(tiles_y), .row_stride(row_stride), .func_in(func_in),
        .reg_in(reg_in), .cmd(if0), .busy(busy0), .done(done0)
    );

    risk_tile_walker #(.GAP(2), .TILE(4)) dut2 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .base_addr(base_addr),
        .tiles_x(tiles_x), .tiles_y(tiles_y), .row_stride(row_stride), .func_in(func_in),
        .reg_in(reg_in), .cmd(if2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(input logic [13:0] sy, input logic [2:0] f, input logic [4:0] r,
                                input logic [5:0] ty, input logic [5:0] tx, input logic [14:0] a);
        return {sy, f, r, ty, tx, a};
    endfunction

    function automatic int first_diff(input rec_t got[$], input rec_t want[$]);
        for (int i = 0; i < want.size(); i++)
            if (i >= got.size() || got[i] !== want[i]) return i;
        if (got.size() != want.size()) return want.size();
        return -1;
    endfunction

    function automatic rec_t rec_at(input rec_t q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return '0;
    endfunction

    function automatic int tr_diff(input logic [1:0] got[$], input logic [1:0] want[$]);
        for (int i = 0; i < want.size(); i++)
            if (i >= got.size() || got[i] !== want[i]) return i;
        return -1;
    endfunction

    // Reference walk: raster order, origin = base + 4*x + 4*stride*y mod 2^15.
    task automatic build_exp(input logic [14:0] b, input int tx, input int ty,
                             input logic [13:0] s, input logic [2:0] f, input logic [4:0] r);
        exp_q.delete();
        for (int y = 0; y < ty; y++)
            for (int x = 0; x < tx; x++)
                exp_q.push_back(mk(s, f, r, 6'(y), 6'(x), 15'(int'(b) + 4 * x + 4 * int'(s) * y)));
    endtask

    // Monitors: log per-cycle {done,valid}, handshakes, and check hold-while-stalled.
    rec_t p0, p2;
    logic st0 = 1'b0, st2 = 1'b0;

    always @(negedge clk) begin
        rec_t cur;
        cur = mk(if0.cmd_stride_y, if0.cmd_func, if0.cmd_reg, if0.tile_y, if0.tile_x, if0.cmd_addr);
        if (!reset) begin
            tr0.push_back({done0, if0.cmd_valid});
            if (done0) dn0++;
            if (if0.cmd_valid && ready) hs0.push_back(cur);
            if (if0.cmd_valid) begin
                n_cmp++;
                if (if0.cmd_stride_x !== 14'd1) begin
                    n_err++;
                    $display("FAIL stride_x0 got %0d want 1", if0.cmd_stride_x);
                end
            end
            if (st0) begin
                n_cmp++;
                if (if0.cmd_valid !== 1'b1 || cur !== p0) begin
                    n_err++;
                    $display("FAIL hold0 got v=%b %h want v=1 %h", if0.cmd_valid, cur, p0);
                end
            end
        end
        st0 = !reset && if0.cmd_valid && !ready && !abort;
        p0  = cur;
    end

    always @(negedge clk) begin
        rec_t cur;
        cur = mk(if2.cmd_stride_y, if2.cmd_func, if2.cmd_reg, if2.tile_y, if2.tile_x, if2.cmd_addr);
        if (!reset) begin
            tr2.push_back({done2, if2.cmd_valid});
            if (done2) dn2++;
            if (if2.cmd_valid && ready) hs2.push_back(cur);
            if (st2) begin
                n_cmp++;
                if (if2.cmd_valid !== 1'b1 || cur !== p2) begin
                    n_err++;
                    $display("FAIL hold2 got v=%b %h want v=1 %h", if2.cmd_valid, cur, p2);
                end
            end
        end
        st2 = !reset && if2.cmd_valid && !ready && !abort;
        p2  = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [14:0] b, input logic [5:0] tx, input logic [5:0] ty,
                            input logic [13:0] s, input logic [2:0] f, input logic [4:0] r);
        base_addr = b; tiles_x = tx; tiles_y = ty; row_stride = s; func_in = f; reg_in = r;
        start = 1'b1;
        hs0.delete(); hs2.delete(); tr0.delete(); tr2.delete();
        dn0 = 0; dn2 = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (!busy0 && !busy2) begin
                timeout = 1'b0;
                break;
            end
            tick();
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({if0.cmd_valid, busy0, done0, if2.cmd_valid, busy2, done2} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_status got %b want 000000",
                     {if0.cmd_valid, busy0, done0, if2.cmd_valid, busy2, done2});
        end
        n_cmp++;
        if ({if0.cmd_addr, if0.cmd_func, if0.cmd_reg, if0.tile_x, if0.tile_y, if0.cmd_stride_y} !== '0) begin
            n_err++;
            $display("FAIL reset_fields0 got addr=%h func=%0d reg=%0d tx=%0d ty=%0d sy=%0d want all 0",
                     if0.cmd_addr, if0.cmd_func, if0.cmd_reg, if0.tile_x, if0.tile_y, if0.cmd_stride_y);
        end
        n_cmp++;
        if ({if0.cmd_stride_x, if2.cmd_stride_x} !== {14'd1, 14'd1}) begin
            n_err++;
            $display("FAIL reset_stride_x got %0d/%0d want 1/1", if0.cmd_stride_x, if2.cmd_stride_x);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bit to; int d;
        logic [1:0] et[$];
        do_start(15'h0010, 6'd2, 6'd2, 14'd16, 3'd3, 5'd7);
        wait_idle(to);
        build_exp(15'h0010, 2, 2, 14'd16, 3'd3, 5'd7);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL basic_timeout got busy want idle"); end
        d = first_diff(hs0, exp_q); n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL basic_hs0 idx %0d got %h want %h (%0d vs %0d cmds)", d,
                     rec_at(hs0, d), rec_at(exp_q, d), hs0.size(), exp_q.size());
        end
        d = first_diff(hs2, exp_q); n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL basic_hs2 idx %0d got %h want %h (%0d vs %0d cmds)", d,
                     rec_at(hs2, d), rec_at(exp_q, d), hs2.size(), exp_q.size());
        end
        et = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
        d = tr_diff(tr0, et); n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL basic_timing cycle %0d got %b want %b", d,
                     (d < tr0.size()) ? tr0[d] : 2'bxx, et[d]);
        end
        n_cmp++;
        if (dn0 != 1 || dn2 != 1) begin
            n_err++;
            $display("FAIL basic_done got %0d/%0d pulses want 1/1", dn0, dn2);
        end
    endtask

    task automatic test_stall();
        bit to; int d; int stalls; int held;
        stalls = 0; held = 0; to = 1'b1;
        do_start(15'h0010, 6'd2, 6'd2, 14'd16, 3'd1, 5'd2);
        for (int i = 0; i < 200; i++) begin
            if (!busy0 && !busy2) begin to = 1'b0; break; end
            if (if0.cmd_valid && if0.cmd_addr == 15'h0014) held++;
            if (if0.cmd_valid && if0.tile_x == 6'd1 && if0.tile_y == 6'd0 && stalls < 3) begin
                ready = 1'b0;
                stalls++;
            end else begin
                ready = 1'b1;
            end
            tick();
        end
        ready = 1'b1;
        tick(); tick();
        build_exp(15'h0010, 2, 2, 14'd16, 3'd1, 5'd2);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL stall_timeout got busy want idle"); end
        n_cmp++;
        if (held != 4) begin n_err++; $display("FAIL stall_held got %0d cycles want 4", held); end
        d = first_diff(hs0, exp_q); n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL stall_hs0 idx %0d got %h want %h (%0d vs %0d cmds)", d,
                     rec_at(hs0, d), rec_at(exp_q, d), hs0.size(), exp_q.size());
        end
        d = first_diff(hs2, exp_q); n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL stall_hs2 idx %0d got %h want %h (%0d vs %0d cmds)", d,
                     rec_at(hs2, d), rec_at(exp_q, d), hs2.size(), exp_q.size());
        end
    endtask

    task automatic test_gap();
        bit to; int d;
        logic [1:0] e0[$], e2[$];
        do_start(15'h0100, 6'd3, 6'd1, 14'd5, 3'd6, 5'd17);
        wait_idle(to);
        build_exp(15'h0100, 3, 1, 14'd5, 3'd6, 5'd17);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL gap_timeout got busy want idle"); end
        e0 = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00};
        e2 = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
        d = tr_diff(tr0, e0); n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL gap0_timing cycle %0d got %b want %b", d, (d < tr0.size()) ? tr0[d] : 2'bxx, e0[d]);
        end
        d = tr_diff(tr2, e2); n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL gap2_timing cycle %0d got %b want %b", d, (d < tr2.size()) ? tr2[d] : 2'bxx, e2[d]);
        end
        d = first_diff(hs2, exp_q); n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL gap_hs2 idx %0d got %h want %h (%0d vs %0d cmds)", d,
                     rec_at(hs2, d), rec_at(exp_q, d), hs2.size(), exp_q.size());
        end
    endtask

    task automatic test_zero_tiles();
        bit to; int d;
        logic [1:0] et[$];
        et = '{2'b00, 2'b10, 2'b00};
        for (int k = 0; k < 2; k++) begin
            do_start(15'h0040, (k == 0) ? 6'd0 : 6'd3, (k == 0) ? 6'd3 : 6'd0, 14'd9, 3'd2, 5'd3);
            wait_idle(to);
            n_cmp++;
            if (hs0.size() != 0 || hs2.size() != 0) begin
                n_err++;
                $display("FAIL zero_hs case %0d got %0d/%0d cmds want 0/0", k, hs0.size(), hs2.size());
            end
            d = tr_diff(tr0, et); n_cmp++;
            if (d >= 0) begin
                n_err++;
                $display("FAIL zero_done0 case %0d cycle %0d got %b want %b", k, d,
                         (d < tr0.size()) ? tr0[d] : 2'bxx, et[d]);
            end
            d = tr_diff(tr2, et); n_cmp++;
            if (d >= 0) begin
                n_err++;
                $display("FAIL zero_done2 case %0d cycle %0d got %b want %b", k, d,
                         (d < tr2.size()) ? tr2[d] : 2'bxx, et[d]);
            end
        end
    endtask

    task automatic test_wrap();
        bit to; int d;
        do_start(15'h7FFC, 6'd2, 6'd1, 14'd100, 3'd0, 5'd31);
        wait_idle(to);
        build_exp(15'h7FFC, 2, 1, 14'd100, 3'd0, 5'd31);
        n_cmp++;
        if (hs0.size() != 2 || hs0[hs0.size()-1][14:0] !== 15'h0000) begin
            n_err++;
            $display("FAIL wrap_addr got %0d cmds last %h want 2 cmds last 0000",
                     hs0.size(), rec_at(hs0, hs0.size() - 1) & 49'h7FFF);
        end
        d = first_diff(hs2, exp_q); n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL wrap_hs2 idx %0d got %h want %h", d, rec_at(hs2, d), rec_at(exp_q, d));
        end
    endtask

    task automatic test_abort();
        bit to; int d; bit aborted;
        rec_t e0[$], e2[$];
        aborted = 1'b0;
        do_start(15'h0020, 6'd2, 6'd2, 14'd8, 3'd5, 5'd9);
        for (int i = 0; i < 12; i++) begin
            if (!aborted && hs0.size() == 2) begin
                abort = 1'b1; ready = 1'b0; aborted = 1'b1;
            end else begin
                abort = 1'b0; ready = 1'b1;
            end
            tick();
        end
        abort = 1'b0; ready = 1'b1;
        build_exp(15'h0020, 2, 2, 14'd8, 3'd5, 5'd9);
        e0 = exp_q[0:1];
        e2 = exp_q[0:0];
        d = first_diff(hs0, e0); n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL abort_hs0 idx %0d got %h want %h (%0d vs 2 cmds)", d, rec_at(hs0, d), rec_at(e0, d), hs0.size());
        end
        d = first_diff(hs2, e2); n_cmp++;
        if (d >= 0) begin
            n_err++;
            $display("FAIL abort_hs2 idx %0d got %h want %h (%0d vs 1 cmds)", d, rec_at(hs2, d), rec_at(e2, d), hs2.size());
        end
        n_cmp++;
        if ({busy0, if0.cmd_valid, busy2, if2.cmd_valid} !== 4'b0 || dn0 != 0 || dn2 != 0) begin
            n_err++;
            $display("FAIL abort_idle got busy/valid %b done %0d/%0d want 0000 done 0/0",
                     {busy0, if0.cmd_valid, busy2, if2.cmd_valid}, dn0, dn2);
        end
        // start together with abort in IDLE must not launch a walk
        abort = 1'b1;
        do_start(15'h0020, 6'd2, 6'd2, 14'd8, 3'd5, 5'd9);
        abort = 1'b0;
        tick();
        n_cmp++;
        if ({busy0, if0.cmd_valid, busy2, if2.cmd_valid} !== 4'b0 || dn0 != 0) begin
            n_err++;
            $display("FAIL abort_start got busy/valid %b done %0d want 0000 done 0",
                     {busy0, if0.cmd_valid, busy2, if2.cmd_valid}, dn0);
        end
        do_start(15'h0020, 6'd2, 6'd2, 14'd8, 3'd5, 5'd9);
        wait_idle(to);
        d = first_diff(hs0, exp_q); n_cmp++;
        if (to || d >= 0 || dn0 != 1) begin
            n_err++;
            $display("FAIL abort_rerun0 idx %0d got %h want %h done %0d want 1", d,
                     rec_at(hs0, d), rec_at(exp_q, d), dn0);
        end
        d = first_diff(hs2, exp_q); n_cmp++;
        if (to || d >= 0 || dn2 != 1) begin
            n_err++;
            $display("FAIL abort_rerun2 idx %0d got %h want %h done %0d want 1", d,
                     rec_at(hs2, d), rec_at(exp_q, d), dn2);
        end
    endtask

    task automatic test_reset_midwalk();
        bit to; int d;
        do_start(15'h0333, 6'd3, 6'd3, 14'd40, 3'd4, 5'd12);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({busy0, if0.cmd_valid, busy2, if2.cmd_valid} !== 4'b0 || if0.cmd_addr !== 15'h0) begin
            n_err++;
            $display("FAIL midreset got busy/valid %b addr %h want 0000 addr 0000",
                     {busy0, if0.cmd_valid, busy2, if2.cmd_valid}, if0.cmd_addr);
        end
        reset = 1'b0;
        do_start(15'h0200, 6'd3, 6'd2, 14'd33, 3'd7, 5'd21);
        n_cmp++;
        if (if0.cmd_valid !== 1'b1 || if0.cmd_addr !== 15'h0200) begin
            n_err++;
            $display("FAIL midreset_restart got v=%b addr %h want v=1 addr 0200", if0.cmd_valid, if0.cmd_addr);
        end
        wait_idle(to);
        build_exp(15'h0200, 3, 2, 14'd33, 3'd7, 5'd21);
        d = first_diff(hs0, exp_q); n_cmp++;
        if (to || d >= 0) begin
            n_err++;
            $display("FAIL midreset_hs0 idx %0d got %h want %h", d, rec_at(hs0, d), rec_at(exp_q, d));
        end
    endtask

    task automatic test_random();
        bit to; int d;
        logic [14:0] b; logic [5:0] tx, ty; logic [13:0] s; logic [2:0] f; logic [4:0] r;
        for (int it = 0; it < 25; it++) begin
            b  = 15'($urandom);
            tx = 6'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5));
            ty = 6'(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4));
            s  = 14'($urandom);
            f  = 3'($urandom);
            r  = 5'($urandom);
            do_start(b, tx, ty, s, f, r);
            to = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if (!busy0 && !busy2) begin start = 1'b0; to = 1'b0; break; end
                ready = ($urandom_range(0, 3) != 0);
                // start pulses while busy, with fresh inputs, must not disturb the walk
                if (busy0 && busy2 && $urandom_range(0, 4) == 0) begin
                    start = 1'b1; base_addr = 15'($urandom); tiles_x = 6'($urandom);
                    row_stride = 14'($urandom); func_in = 3'($urandom);
                end else begin
                    start = 1'b0;
                end
                tick();
            end
            start = 1'b0; ready = 1'b1;
            tick(); tick();
            build_exp(b, int'(tx), int'(ty), s, f, r);
            d = first_diff(hs0, exp_q); n_cmp++;
            if (to || d >= 0 || dn0 != 1) begin
                n_err++;
                $display("FAIL rand%0d_dut0 idx %0d got %h want %h cmds %0d/%0d done %0d", it, d,
                         rec_at(hs0, d), rec_at(exp_q, d), hs0.size(), exp_q.size(), dn0);
            end
            d = first_diff(hs2, exp_q); n_cmp++;
            if (to || d >= 0 || dn2 != 1) begin
                n_err++;
                $display("FAIL rand%0d_dut2 idx %0d got %h want %h cmds %0d/%0d done %0d", it, d,
                         rec_at(hs2, d), rec_at(exp_q, d), hs2.size(), exp_q.size(), dn2);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        base_addr = '0; tiles_x = '0; tiles_y = '0; row_stride = '0; func_in = '0; reg_in = '0;
        test_reset();
        test_basic();
        test_stall();
        test_gap();
        test_zero_tiles();
        test_wrap();
        test_abort();
        test_reset_midwalk();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/risk_tile_walker.md
RISK_TILE_WALKER -- requirements
Module: risk_tile_walker

Interface
REQ-001 Parameter GAP, default 0: idle cycles inserted after each accepted command (0..15).
REQ-002 Parameter TILE, default 4: tile edge in elements; fixed 4, matches 4x4 register tiles.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin walk; sampled only in IDLE.
REQ-006 abort  input  1  cancel walk in progress; takes priority over all except reset.
REQ-007 base_addr  input  15  element address of matrix origin.
REQ-008 tiles_x  input  6  tiles per row (0..63).
REQ-009 tiles_y  input  6  tile rows (0..63).
REQ-010 row_stride  input  14  elements between consecutive matrix rows.
REQ-011 func_in  input  3  risk function code copied to every command.
REQ-012 reg_in  input  5  risk register index copied to every command.
REQ-013 cmd_valid  output  1  command presented.
REQ-014 cmd_ready  input  1  downstream accepts command; handshake = cmd_valid & cmd_ready.
REQ-015 cmd_func  output  3  function code for this tile.
REQ-016 cmd_reg  output  5  register index for this tile.
REQ-017 cmd_addr  output  15  tile origin element address.
REQ-018 cmd_stride_x  output  14  element step along x; constant 1.
REQ-019 cmd_stride_y  output  14  element step along y; equals latched row_stride.
REQ-020 tile_x, tile_y  output  6 each  coordinates of the presented tile.
REQ-021 busy  output  1  high in ISSUE and GAP states.
REQ-022 done  output  1  one-cycle pulse when walk completes normally.

Function
REQ-023 States: IDLE, ISSUE, GAP; FSM is fully registered, all outputs driven from flops.
REQ-024 IDLE + start: latch base_addr, tiles_x, tiles_y, row_stride, func_in, reg_in; clear tile_x/tile_y; enter ISSUE; cmd_valid high the next cycle (1-cycle start latency).
REQ-025 start with tiles_x==0 or tiles_y==0: no command issued; stay IDLE; done pulses the cycle after start.
REQ-026 start while busy is ignored; latched parameters do not change mid-walk.
REQ-027 Walk order raster: tile_x increments first, wraps to 0 at tiles_x-1 with tile_y incrementing.
REQ-028 cmd_addr = base + 4*tile_x + 4*row_stride*tile_y, truncated mod 2^15; computed incrementally (row-base register advanced by 4*row_stride per row), no multiplier.
REQ-029 While cmd_valid & !cmd_ready, all cmd_* and tile_* outputs hold stable.
REQ-030 On handshake with more tiles: GAP==0 -> next tile presented the following cycle (one command per cycle at full throughput); GAP>0 -> cmd_valid low for exactly GAP cycles in GAP state, then ISSUE with next tile.
REQ-031 On handshake of last tile (tile_x==tiles_x-1, tile_y==tiles_y-1): cmd_valid low next cycle, busy low, done high for one cycle, state IDLE; GAP cycles are not inserted after last tile.
REQ-032 abort in ISSUE or GAP: next cycle state IDLE, cmd_valid low, busy low, done stays low; a handshake in the abort cycle counts as accepted, no further command issues.
REQ-033 abort and start together in IDLE: start ignored.
REQ-034 Address wrap past 0x7FFF is silent modulo wrap, no error.

Reset
REQ-035 reset forces IDLE; cmd_valid, busy, done = 0; cmd_addr, cmd_func, cmd_reg, tile_x, tile_y, cmd_stride_y = 0; cmd_stride_x = 1.
REQ-036 reset mid-walk drops the pending command immediately; first cycle after reset release is IDLE and accepts start.

Verification
REQ-037 base=0x0010, tiles_x=2, tiles_y=2, row_stride=16, ready=1, GAP=0 -> cmd_addr 0x0010,0x0014,0x0050,0x0054 on 4 consecutive cycles; done one cycle after last.
REQ-038 Same walk, ready low for 3 cycles on tile 1 -> 0x0014 held stable 4 cycles, no tile skipped or duplicated.
REQ-039 GAP=2, tiles_x=3, tiles_y=1 -> valid pattern 1,0,0,1,0,0,1 then done.
REQ-040 tiles_x=0 -> zero handshakes, done pulses exactly one cycle after start.
REQ-041 base=0x7FFC, tiles_x=2, tiles_y=1 -> addrs 0x7FFC, 0x0000.
REQ-042 abort after 2nd handshake of a 4-tile walk -> exactly 2 handshakes, no done; subsequent start runs a full walk correctly.
